// File: rtl/shift_reg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift register sequencer: the controller state
// encoding, the shift direction constants and the default register width.
// -----------------------------------------------------------------------------
package shift_seq_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      SHIFT = 2'b10,
      CHECK = 2'b11
   } state_e;

   // Direction encoding as seen on req_dir and sr_shift
   localparam logic DIR_RIGHT = 1'b0;   // new bit enters the MSB
   localparam logic DIR_LEFT  = 1'b1;   // new bit enters the LSB

   // Default shift register / request word width
   localparam int DEFAULT_WIDTH = 4;

endpackage : shift_seq_pkg

// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer
// Controller for one bidirectional serial shift register. A word and a
// direction are accepted through a valid/ready handshake, the register is
// cleared for one cycle, the word is driven in serially (LSB first for a right
// shift, MSB first for a left shift), and the register's parallel output is
// then compared against the word. The result is posted with a one-cycle done
// pulse and held until the next result.
//
// Ports
//   clk          rising-edge clock, shared with the shift register
//   reset        asynchronous active-high reset
//   req_valid    request present
//   req_ready    high only in IDLE
//   req_dir      0 = right shift, 1 = left shift
//   req_data     word to be loaded serially
//   sr_reset     shift register reset (controller reset OR CLEAR state)
//   sr_shift     shift register direction input
//   sr_data_in   shift register serial input
//   sr_data_out  shift register parallel output
//   busy         high in every state except IDLE
//   done         one-cycle result pulse
//   rsp_data     register contents captured in CHECK
//   rsp_match    rsp_data equals the requested word
// -----------------------------------------------------------------------------
module shift_reg_sequencer
   import shift_seq_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_dir,
   input  logic [WIDTH-1:0] req_data,
   output logic             sr_reset,
   output logic             sr_shift,
   output logic             sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_match
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q,     state_d;
   logic [WIDTH-1:0]   word_q,      word_d;
   logic               dir_q,       dir_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               done_q,      done_d;
   logic [WIDTH-1:0]   rsp_data_q,  rsp_data_d;
   logic               rsp_match_q, rsp_match_d;
   logic               sr_data_in_s;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         word_q      <= {WIDTH{1'b0}};
         dir_q       <= DIR_RIGHT;
         cnt_q       <= {CNT_W{1'b0}};
         done_q      <= 1'b0;
         rsp_data_q  <= {WIDTH{1'b0}};
         rsp_match_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         rsp_data_q  <= rsp_data_d;
         rsp_match_q <= rsp_match_d;
      end
   end

   // Next-state and datapath update logic
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_match_d = rsp_match_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               word_d  = req_data;
               dir_d   = req_dir;
               state_d = CLEAR;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = SHIFT;
         end
         SHIFT: begin
            // Exit on the last bit; the counter is never advanced past CNT_LAST
            if (cnt_q == CNT_LAST) begin
               state_d = CHECK;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = SHIFT;
            end
         end
         CHECK: begin
            rsp_data_d  = sr_data_out;
            rsp_match_d = (sr_data_out == word_q);
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Serial bit select, decoded from registered state and counter only
   always_comb begin
      sr_data_in_s = 1'b0;
      if (state_q == SHIFT) begin
         if (dir_q == DIR_LEFT) begin
            sr_data_in_s = word_q[CNT_LAST - cnt_q];
         end else begin
            sr_data_in_s = word_q[cnt_q];
         end
      end else begin
         sr_data_in_s = 1'b0;
      end
   end

   // The register clears with the controller, and for the single CLEAR cycle
   assign sr_reset   = reset | (state_q == CLEAR);
   // Direction is held between transfers so the register never sees a spurious change
   assign sr_shift   = dir_q;
   assign sr_data_in = sr_data_in_s;

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_match  = rsp_match_q;

endmodule : shift_reg_sequencer
